// File: rtl/regfile_read_arbiter.sv
// Two-channel read arbiter in front of a 32x32 register file's combinational read port.
// Define RR_ARB_EN for round-robin on contention; otherwise channel A has fixed priority.
module regfile_read_arbiter (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        a_req,
  input  logic [4:0]  a_index,
  output logic        a_ack,
  output logic [31:0] a_data,
  input  logic        b_req,
  input  logic [4:0]  b_index,
  output logic        b_ack,
  output logic [31:0] b_data,
  output logic [4:0]  rf_read_index,
  input  logic [31:0] rf_read_value,
  output logic        busy,
  output logic [15:0] read_count
);

  typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = channel B owns the transaction
  logic [4:0]  index_q, index_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic [31:0] a_data_q, a_data_d;
  logic [31:0] b_data_q, b_data_d;
  logic [15:0] read_count_q, read_count_d;
  logic        grant_b;

`ifdef RR_ARB_EN
  logic last_b_q, last_b_d;

  // On contention the channel not granted last wins.
  assign grant_b = b_req & (~a_req | ~last_b_q);
`else
  assign grant_b = b_req & ~a_req;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    index_d      = index_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_data_d     = a_data_q;
    b_data_d     = b_data_q;
    read_count_d = read_count_q;
`ifdef RR_ARB_EN
    last_b_d     = last_b_q;
`endif
    case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          state_d = StRead;
          owner_d = grant_b;
          index_d = grant_b ? b_index : a_index;
`ifdef RR_ARB_EN
          last_b_d = grant_b;
`endif
        end
      end
      StRead: begin
        state_d = StDone;
        if (owner_q) begin
          b_data_d = rf_read_value;
          b_ack_d  = 1'b1;
        end else begin
          a_data_d = rf_read_value;
          a_ack_d  = 1'b1;
        end
        if (read_count_q != 16'hFFFF) begin
          read_count_d = read_count_q + 16'd1;
        end
      end
      StDone: begin
        // Requests are deliberately not sampled here.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      index_q      <= 5'd0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_data_q     <= 32'd0;
      b_data_q     <= 32'd0;
      read_count_q <= 16'd0;
`ifdef RR_ARB_EN
      last_b_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      index_q      <= index_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_data_q     <= a_data_d;
      b_data_q     <= b_data_d;
      read_count_q <= read_count_d;
`ifdef RR_ARB_EN
      last_b_q     <= last_b_d;
`endif
    end
  end

  assign a_ack         = a_ack_q;
  assign b_ack         = b_ack_q;
  assign a_data        = a_data_q;
  assign b_data        = b_data_q;
  assign rf_read_index = index_q;
  assign read_count    = read_count_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: transaction-level model checked every cycle, plus
// hand-computed pins for reset, latency, arbitration, write-in-READ and saturation.
module tb_regfile_read_arbiter;

  logic        clock;
  logic        clear_n;
  logic        a_req, b_req;
  logic [4:0]  a_index, b_index;
  logic        a_ack, b_ack;
  logic [31:0] a_data, b_data;
  logic [4:0]  rf_read_index;
  logic [31:0] rf_read_value;
  logic        busy;
  logic [15:0] read_count;

  logic [31:0] rf_mem [32];

  int checks = 0;
  int errors = 0;
  int count_bias = 0;

  regfile_read_arbiter dut (
    .clock         (clock),
    .clear_n       (clear_n),
    .a_req         (a_req),
    .a_index       (a_index),
    .a_ack         (a_ack),
    .a_data        (a_data),
    .b_req         (b_req),
    .b_index       (b_index),
    .b_ack         (b_ack),
    .b_data        (b_data),
    .rf_read_index (rf_read_index),
    .rf_read_value (rf_read_value),
    .busy          (busy),
    .read_count    (read_count)
  );

  assign rf_read_value = rf_mem[rf_read_index];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: a transaction is three cycles (grant, read, ack); data is the register file
  // content at the end of the read cycle.
  int          m_phase  = 0;
  logic        m_last_b = 1'b1;
  logic [4:0]  m_idx    = 5'd0;
  logic        m_owner_b = 1'b0;
  logic        m_a_ack  = 1'b0;
  logic        m_b_ack  = 1'b0;
  logic [31:0] m_a_data = 32'd0;
  logic [31:0] m_b_data = 32'd0;
  int          m_total  = 0;

  always @(posedge clock or negedge clear_n) begin
    logic take_b;
    if (!clear_n) begin
      m_phase  <= 0;
      m_last_b <= 1'b1;
      m_idx    <= 5'd0;
      m_owner_b <= 1'b0;
      m_a_ack  <= 1'b0;
      m_b_ack  <= 1'b0;
      m_a_data <= 32'd0;
      m_b_data <= 32'd0;
      m_total  <= 0;
    end else begin
      m_a_ack <= 1'b0;
      m_b_ack <= 1'b0;
      if (m_phase == 0) begin
        if (a_req || b_req) begin
          if (a_req && b_req) begin
`ifdef RR_ARB_EN
            take_b = (m_last_b == 1'b0);
`else
            take_b = 1'b0;
`endif
          end else begin
            take_b = b_req;
          end
          m_last_b  <= take_b;
          m_owner_b <= take_b;
          m_idx     <= take_b ? b_index : a_index;
          m_phase   <= 1;
        end
      end else if (m_phase == 1) begin
        if (m_owner_b) begin
          m_b_data <= rf_mem[m_idx];
          m_b_ack  <= 1'b1;
        end else begin
          m_a_data <= rf_mem[m_idx];
          m_a_ack  <= 1'b1;
        end
        m_total <= m_total + 1;
        m_phase <= 2;
      end else begin
        m_phase <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    int exp_count;
    exp_count = m_total + count_bias;
    if (exp_count > 65535) exp_count = 65535;
    chk("a_ack", {31'd0, a_ack}, {31'd0, m_a_ack});
    chk("b_ack", {31'd0, b_ack}, {31'd0, m_b_ack});
    chk("a_data", a_data, m_a_data);
    chk("b_data", b_data, m_b_data);
    chk("busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
    chk("read_count", {16'd0, read_count}, exp_count);
    chk("rf_read_index", {27'd0, rf_read_index}, {27'd0, m_idx});
  endtask

  // One clock: compare just after the rising edge, return at the falling edge.
  task automatic step();
    @(posedge clock);
    #1;
    if (clear_n) compare_all();
    @(negedge clock);
  endtask

  // Present requests, drop each on its ack, return once idle. first: 0 none, 1 A, 2 B.
  task automatic serve(input logic ar, input logic [4:0] ai, input logic br,
                       input logic [4:0] bi, output int first);
    logic done;
    a_req = ar; a_index = ai; b_req = br; b_index = bi;
    first = 0;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      step();
      if (a_ack) begin
        if (first == 0) first = 1;
        a_req = 1'b0;
      end
      if (b_ack) begin
        if (first == 0) first = 2;
        b_req = 1'b0;
      end
      if (!a_req && !b_req && !busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL serve_timeout actual=busy required=idle");
      a_req = 1'b0;
      b_req = 1'b0;
    end
  endtask

  initial begin
    int first;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + i * 32'h111;
    rf_mem[5]  = 32'h0000_0439;
    rf_mem[1]  = 32'd2553;
    rf_mem[2]  = 32'd66;
    rf_mem[13] = 32'd111;
    clear_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0; a_index = 5'd0; b_index = 5'd0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_a_ack", {31'd0, a_ack}, 32'd0);
    chk("rst_b_ack", {31'd0, b_ack}, 32'd0);
    chk("rst_a_data", a_data, 32'd0);
    chk("rst_b_data", b_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {16'd0, read_count}, 32'd0);
    chk("rst_index", {27'd0, rf_read_index}, 32'd0);

    // Request already high when reset lifts: the first edge grants.
    @(negedge clock);
    a_req = 1'b1; a_index = 5'd5;
    clear_n = 1'b1;
    step();
    chk("e0_busy", {31'd0, busy}, 32'd1);
    chk("e0_index", {27'd0, rf_read_index}, 32'd5);
    chk("e0_a_ack", {31'd0, a_ack}, 32'd0);
    step();
    chk("e1_a_ack", {31'd0, a_ack}, 32'd1);
    chk("e1_a_data", a_data, 32'h0000_0439);
    chk("e1_count", {16'd0, read_count}, 32'd1);
    a_req = 1'b0;
    step();
    chk("e2_a_ack", {31'd0, a_ack}, 32'd0);
    chk("e2_index_hold", {27'd0, rf_read_index}, 32'd5);

    // Register written on the falling edge inside READ is what B receives.
    b_req = 1'b1; b_index = 5'd13;
    step();
    rf_mem[13] = 32'd54210;
    step();
    chk("wr_in_read_b_ack", {31'd0, b_ack}, 32'd1);
    chk("wr_in_read_b_data", b_data, 32'd54210);
    b_req = 1'b0;
    step();

    // B pulses only during the DONE cycle of an A transaction: never granted.
    a_req = 1'b1; a_index = 5'd3;
    step();
    step();
    chk("pulse_a_ack", {31'd0, a_ack}, 32'd1);
    a_req = 1'b0;
    b_req = 1'b1; b_index = 5'd9;
    step();
    b_req = 1'b0;
    step();
    step();
    chk("pulse_busy", {31'd0, busy}, 32'd0);
    chk("pulse_b_ack", {31'd0, b_ack}, 32'd0);
    chk("pulse_b_data", b_data, 32'd54210);

    // Reset asserted in the middle of READ.
    a_req = 1'b1; a_index = 5'd1;
    step();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    count_bias = 0;
    clear_n = 1'b0;
    a_req = 1'b0;
    #1;
    chk("mid_rst_a_ack", {31'd0, a_ack}, 32'd0);
    chk("mid_rst_b_ack", {31'd0, b_ack}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_count", {16'd0, read_count}, 32'd0);
    chk("mid_rst_a_data", a_data, 32'd0);
    chk("mid_rst_b_data", b_data, 32'd0);
    @(negedge clock);
    clear_n = 1'b1;
    step();

    // Contention fresh from reset: A first, B follows while still requesting.
    serve(1'b1, 5'd1, 1'b1, 5'd2, first);
    chk("cont1_first", first, 32'd1);
    chk("cont1_a_data", a_data, 32'd2553);
    chk("cont1_b_data", b_data, 32'd66);
    // A alone, so A was granted last before the next contention.
    serve(1'b1, 5'd5, 1'b0, 5'd0, first);
    chk("alone_first", first, 32'd1);
    serve(1'b1, 5'd2, 1'b1, 5'd1, first);
`ifdef RR_ARB_EN
    chk("cont3_first", first, 32'd2);
`else
    chk("cont3_first", first, 32'd1);
`endif
    chk("cont_count", {16'd0, read_count}, 32'd5);

    // Saturation: preload the counter just below the ceiling.
    count_bias = 65534 - m_total;
    force dut.read_count_q = 16'hFFFE;
    #1;
    release dut.read_count_q;
    serve(1'b0, 5'd0, 1'b1, 5'd2, first);
    chk("sat1_count", {16'd0, read_count}, 32'h0000_FFFF);
    serve(1'b0, 5'd0, 1'b1, 5'd5, first);
    chk("sat2_ack", first, 32'd2);
    chk("sat2_count", {16'd0, read_count}, 32'h0000_FFFF);
    chk("sat2_b_data", b_data, 32'h0000_0439);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
